// File: rtl/game_flow_sequencer.sv
// rtl/game_flow_sequencer.sv - frame-timed sequencer for info, countdown, GO and game-over overlays
module game_flow_sequencer #(
    parameter int FRAME_RATE   = 60,
    parameter int COUNT_FROM   = 3,
    parameter int GO_FRAMES    = 45,
    parameter int BLINK_FRAMES = 30,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       game_over,
    output logic       info_en,
    output logic       countdown_en,
    output logic [2:0] countdown_digit,
    output logic       go_en,
    output logic       over_en,
    output logic       game_run
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INFO,
        S_COUNT,
        S_GO,
        S_PLAY,
        S_OVER
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_RATE - 1);
    localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GO_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       DIGIT_INIT = 3'(COUNT_FROM);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]       digit_q, digit_d;
    logic             blink_q, blink_d;
    logic             vsync_q, key_q;
    logic             info_en_q, info_en_d;
    logic             countdown_en_q, countdown_en_d;
    logic             go_en_q, go_en_d;
    logic             over_en_q, over_en_d;
    logic             game_run_q, game_run_d;

    logic key_any;
    logic frame_tick;
    logic key_evt;

    assign key_any    = key_left | key_right;
    assign frame_tick = vsync & ~vsync_q;
    assign key_evt    = key_any & ~key_q;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        digit_d     = digit_q;
        blink_d     = blink_q;

        case (state_q)
            S_IDLE: state_d = S_INFO;
            S_INFO: begin
                if (key_evt) begin
                    state_d = S_COUNT;
                    digit_d = DIGIT_INIT;
                end
            end
            S_COUNT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        if (digit_q == 3'd1) begin
                            state_d = S_GO;
                        end else begin
                            digit_d = digit_q - 3'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_GO: begin
                // game_over outranks the GO timer expiring on the same cycle
                if (game_over) begin
                    state_d = S_OVER;
                    blink_d = 1'b1;
                end else if (frame_tick) begin
                    if (frame_cnt_q == GO_LAST) begin
                        state_d = S_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (game_over) begin
                    state_d = S_OVER;
                    blink_d = 1'b1;
                end
            end
            S_OVER: begin
                // a key only restarts once the player has respawned
                if (key_evt && !game_over) begin
                    state_d = S_INFO;
                end else if (frame_tick) begin
                    if (frame_cnt_q == BLINK_LAST) begin
                        frame_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end

        info_en_d      = (state_d == S_INFO);
        countdown_en_d = (state_d == S_COUNT);
        go_en_d        = (state_d == S_GO);
        over_en_d      = (state_d == S_OVER) && blink_d;
        game_run_d     = (state_d == S_GO) || (state_d == S_PLAY);
    end

    // edge detectors start high so a level already present at reset release is not an event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            frame_cnt_q    <= '0;
            digit_q        <= DIGIT_INIT;
            blink_q        <= 1'b0;
            vsync_q        <= 1'b1;
            key_q          <= 1'b1;
            info_en_q      <= 1'b0;
            countdown_en_q <= 1'b0;
            go_en_q        <= 1'b0;
            over_en_q      <= 1'b0;
            game_run_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            digit_q        <= digit_d;
            blink_q        <= blink_d;
            vsync_q        <= vsync;
            key_q          <= key_any;
            info_en_q      <= info_en_d;
            countdown_en_q <= countdown_en_d;
            go_en_q        <= go_en_d;
            over_en_q      <= over_en_d;
            game_run_q     <= game_run_d;
        end
    end

    assign info_en         = info_en_q;
    assign countdown_en    = countdown_en_q;
    assign countdown_digit = digit_q;
    assign go_en           = go_en_q;
    assign over_en         = over_en_q;
    assign game_run        = game_run_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb/tb_game_flow_sequencer.sv - scoreboard bench for game_flow_sequencer
module tb_game_flow_sequencer;

    localparam int FRAME_RATE   = 4;
    localparam int COUNT_FROM   = 3;
    localparam int GO_FRAMES    = 2;
    localparam int BLINK_FRAMES = 3;

    localparam int P_IDLE  = 0;
    localparam int P_INFO  = 1;
    localparam int P_COUNT = 2;
    localparam int P_GO    = 3;
    localparam int P_PLAY  = 4;
    localparam int P_OVER  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       game_over = 1'b0;
    logic       info_en, countdown_en, go_en, over_en, game_run;
    logic [2:0] countdown_digit;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int info;
        int cen;
        int dig;
        int go;
        int over;
        int run;
    } exp_t;

    exp_t exp_q[$];

    game_flow_sequencer #(
        .FRAME_RATE  (FRAME_RATE),
        .COUNT_FROM  (COUNT_FROM),
        .GO_FRAMES   (GO_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES),
        .CNT_W       (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .vsync          (vsync),
        .key_left       (key_left),
        .key_right      (key_right),
        .game_over      (game_over),
        .info_en        (info_en),
        .countdown_en   (countdown_en),
        .countdown_digit(countdown_digit),
        .go_en          (go_en),
        .over_en        (over_en),
        .game_run       (game_run)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // vsync: 3-clock pulse every 20 clocks
    initial begin
        forever begin
            repeat (17) @(negedge clk);
            vsync = 1'b1;
            repeat (3) @(negedge clk);
            vsync = 1'b0;
        end
    end

    // Reference model: phase plus frame ticks elapsed since entering that phase
    initial begin
        int phase = P_IDLE;
        int ticks = 0;
        int pvs = 1;
        int pk = 1;
        forever begin
            @(posedge clk);
            if (!rst) begin
                phase = P_IDLE;
                ticks = 0;
                pvs = 1;
                pk = 1;
                exp_q.delete();
            end else begin
                int  vs, k, fe, ke;
                exp_t e;
                vs = int'(vsync);
                k  = int'(key_left | key_right);
                fe = (vs == 1 && pvs == 0) ? 1 : 0;
                ke = (k == 1 && pk == 0) ? 1 : 0;
                pvs = vs;
                pk  = k;
                case (phase)
                    P_IDLE: phase = P_INFO;
                    P_INFO: if (ke == 1) begin phase = P_COUNT; ticks = 0; end
                    P_COUNT: begin
                        ticks += fe;
                        if (ticks == COUNT_FROM * FRAME_RATE) begin phase = P_GO; ticks = 0; end
                    end
                    P_GO: begin
                        if (game_over) begin phase = P_OVER; ticks = 0; end
                        else begin
                            ticks += fe;
                            if (ticks == GO_FRAMES) begin phase = P_PLAY; ticks = 0; end
                        end
                    end
                    P_PLAY: if (game_over) begin phase = P_OVER; ticks = 0; end
                    default: begin
                        if (ke == 1 && !game_over) begin phase = P_INFO; ticks = 0; end
                        else ticks += fe;
                    end
                endcase
                e.info = (phase == P_INFO) ? 1 : 0;
                e.cen  = (phase == P_COUNT) ? 1 : 0;
                e.dig  = COUNT_FROM - ticks / FRAME_RATE;
                e.go   = (phase == P_GO) ? 1 : 0;
                e.over = (phase == P_OVER && ((ticks / BLINK_FRAMES) % 2) == 0) ? 1 : 0;
                e.run  = (phase == P_GO || phase == P_PLAY) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare every presented output cycle against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_info_en", int'(info_en), e.info);
                check("sb_countdown_en", int'(countdown_en), e.cen);
                if (e.cen == 1) check("sb_digit", int'(countdown_digit), e.dig);
                check("sb_go_en", int'(go_en), e.go);
                check("sb_over_en", int'(over_en), e.over);
                check("sb_game_run", int'(game_run), e.run);
                check("sb_onehot", ($countones({info_en, countdown_en, go_en, over_en}) <= 1) ? 1 : 0, 1);
            end
        end
    end

    function automatic int cur(input int sel);
        case (sel)
            0: return int'(info_en);
            1: return int'(countdown_en);
            2: return int'(go_en);
            3: return int'(over_en);
            4: return int'(game_run && !go_en);
            5: return int'(countdown_en && countdown_digit == 3'd2);
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int limit);
        int n = 0;
        while (cur(sel) == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, cur(sel), 1);
    endtask

    task automatic press(input logic l, input logic r);
        @(negedge clk);
        key_left  = l;
        key_right = r;
        repeat (2) @(negedge clk);
        key_left  = 1'b0;
        key_right = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_info_en", int'(info_en), 0);
        check("rst_countdown_en", int'(countdown_en), 0);
        check("rst_digit", int'(countdown_digit), COUNT_FROM);
        check("rst_go_en", int'(go_en), 0);
        check("rst_over_en", int'(over_en), 0);
        check("rst_game_run", int'(game_run), 0);
        #2 rst = 1'b1;

        // 1: idle into info, vsync alone never leaves it
        repeat (2) @(negedge clk);
        check("t1_info_en", int'(info_en), 1);
        repeat (60) @(negedge clk);
        check("t1_stay_info", int'(info_en), 1);

        // 2: countdown, GO, PLAY
        press(1'b0, 1'b1);
        check("t2_count_en", int'(countdown_en), 1);
        check("t2_digit3", int'(countdown_digit), 3);
        wait_for("t2_digit2", 5, 200);
        wait_for("t2_go_en", 2, 400);
        check("t2_go_run", int'(game_run), 1);
        wait_for("t2_play", 4, 100);

        // 3: game over, blink, key gating
        @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        check("t3_run_off", int'(game_run), 0);
        check("t3_over_on", int'(over_en), 1);
        repeat (70) @(negedge clk);
        press(1'b1, 1'b0);
        check("t3_dropped_key", int'(info_en), 0);
        repeat (30) @(negedge clk);
        game_over = 1'b0;
        press(1'b1, 1'b0);
        check("t3_back_info", int'(info_en), 1);

        // 4: key held through reset release
        @(negedge clk);
        key_left = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        check("t4_held_info", int'(info_en), 1);
        key_left = 1'b0;
        repeat (2) @(negedge clk);
        press(1'b1, 1'b0);
        check("t4_count", int'(countdown_en), 1);

        // 5: disturbances during countdown are ignored
        wait_for("t5_digit2", 5, 200);
        @(negedge clk);
        game_over = 1'b1;
        key_left  = 1'b1;
        key_right = 1'b1;
        repeat (2) @(negedge clk);
        game_over = 1'b0;
        key_left  = 1'b0;
        key_right = 1'b0;
        @(negedge clk);
        check("t5_still_count", int'(countdown_en), 1);
        wait_for("t5_go", 2, 400);

        // 6: asynchronous reset in GO
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_go_async", int'(go_en), 0);
        check("t6_run_async", int'(game_run), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_restart_info", int'(info_en), 1);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            key_left  = ($urandom_range(0, 7) == 0);
            key_right = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
        end
        key_left  = 1'b0;
        key_right = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
